// File: rtl/debug_hart_ctrl.sv
// rtl/debug_hart_ctrl.sv - hart-side debug halt/resume FSM and abstract register access
// Optional single-step support is built when DEBUG_HART_STEP_EN is defined.
module debug_hart_ctrl (
    input  logic        CLK100MHZ,
    input  logic        TRST_N,
    input  logic        HALTREQ,
    input  logic        RESUMEREQ,
    output logic        HALTED,
    output logic        RESUMEACK,
    input  logic        AR_REQ,
    input  logic        AR_WR,
    input  logic [15:0] AR_AD,
    input  logic [31:0] AR_WDATA,
    output logic        AR_ACK,
    output logic [31:0] AR_RDATA,
    output logic        AR_ERR,
    output logic        CORE_STALL,
    input  logic        CORE_IDLE,
    input  logic        CORE_RETIRE,
    input  logic [31:0] CORE_PC,
    output logic        CORE_PC_LOAD,
    output logic [31:0] CORE_PC_NEXT,
    output logic [4:0]  GPR_AD,
    input  logic [31:0] GPR_RD,
    output logic        GPR_WE,
    output logic [31:0] GPR_WD
);

    localparam logic [31:0] MISA_VAL = 32'h4000_1105;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALTING   = 2'd1,
        ST_HALTED    = 2'd2,
        ST_RESUMING  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  halt_sync_q, halt_sync_d;
    logic [1:0]  resume_sync_q, resume_sync_d;
    logic [1:0]  arreq_sync_q, arreq_sync_d;
    logic        ar_seen_q, ar_seen_d;
    logic        ar_go_q, ar_go_d;
    logic        ar_ack_q, ar_ack_d;
    logic [31:0] ar_rdata_q, ar_rdata_d;
    logic        ar_err_q, ar_err_d;
    logic        pc_load_q, pc_load_d;
    logic [31:0] dpc_q, dpc_d;
    logic [2:0]  cause_q, cause_d;
    logic        ebreakm_q, ebreakm_d;
    logic        step_rd;
    logic        gpr_we;
    logic        haltreq_s, resumereq_s, ar_req_s;
    logic [31:0] dcsr_rd;

`ifdef DEBUG_HART_STEP_EN
    logic        step_q, step_d;
    logic        armed_q, armed_d;
    logic        hit_q, hit_d;
    assign step_rd = step_q;
`else
    logic        unused_retire;
    assign unused_retire = CORE_RETIRE;
    assign step_rd = 1'b0;
`endif

    assign haltreq_s   = halt_sync_q[1];
    assign resumereq_s = resume_sync_q[1];
    assign ar_req_s    = arreq_sync_q[1];
    assign dcsr_rd     = {4'h4, 12'h000, ebreakm_q, 6'h00, cause_q, 3'b000, step_rd, 2'b11};

    always_comb begin
        state_d       = state_q;
        halt_sync_d   = {halt_sync_q[0], HALTREQ};
        resume_sync_d = {resume_sync_q[0], RESUMEREQ};
        arreq_sync_d  = {arreq_sync_q[0], AR_REQ};
        ar_seen_d     = ar_req_s;
        ar_go_d       = ar_req_s ^ ar_seen_q;
        ar_ack_d      = ar_ack_q;
        ar_rdata_d    = ar_rdata_q;
        ar_err_d      = ar_err_q;
        pc_load_d     = 1'b0;
        dpc_d         = dpc_q;
        cause_d       = cause_q;
        ebreakm_d     = ebreakm_q;
        gpr_we        = 1'b0;
`ifdef DEBUG_HART_STEP_EN
        step_d        = step_q;
        armed_d       = armed_q;
        hit_d         = hit_q;
`endif

        case (state_q)
            ST_RUN: begin
                if (haltreq_s) begin
                    state_d = ST_HALTING;
`ifdef DEBUG_HART_STEP_EN
                    hit_d   = 1'b0;
                    armed_d = 1'b0;
                end else if (armed_q && CORE_RETIRE) begin
                    state_d = ST_HALTING;
                    hit_d   = 1'b1;
                    armed_d = 1'b0;
`endif
                end
            end
            ST_HALTING: begin
                if (CORE_IDLE) begin
                    state_d = ST_HALTED;
                    dpc_d   = CORE_PC;
`ifdef DEBUG_HART_STEP_EN
                    cause_d = hit_q ? 3'd4 : 3'd3;
`else
                    cause_d = 3'd3;
`endif
                end
            end
            ST_HALTED: begin
                // A simultaneous halt request keeps the hart parked.
                if (resumereq_s && !haltreq_s) begin
                    state_d   = ST_RESUMING;
                    pc_load_d = 1'b1;
                end
            end
            default: begin
                if (!resumereq_s) begin
                    state_d = ST_RUN;
`ifdef DEBUG_HART_STEP_EN
                    armed_d = step_q;
`endif
                end
            end
        endcase

        if (ar_go_q) begin
            ar_ack_d   = ~ar_ack_q;
            ar_rdata_d = 32'h0;
            ar_err_d   = 1'b0;
            if (state_q != ST_HALTED) begin
                ar_err_d = 1'b1;
            end else if (AR_AD[15:5] == 11'h080) begin
                if (AR_WR) begin
                    gpr_we = (AR_AD[4:0] != 5'd0);
                end else if (AR_AD[4:0] != 5'd0) begin
                    ar_rdata_d = GPR_RD;
                end
            end else if (AR_AD == 16'h07B0) begin
                if (AR_WR) begin
                    ebreakm_d = AR_WDATA[15];
`ifdef DEBUG_HART_STEP_EN
                    step_d    = AR_WDATA[2];
`endif
                end else begin
                    ar_rdata_d = dcsr_rd;
                end
            end else if (AR_AD == 16'h07B1) begin
                if (AR_WR) begin
                    dpc_d = AR_WDATA;
                end else begin
                    ar_rdata_d = dpc_q;
                end
            end else if (AR_AD == 16'h0301 && !AR_WR) begin
                ar_rdata_d = MISA_VAL;
            end else begin
                ar_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge TRST_N) begin
        if (!TRST_N) begin
            state_q       <= ST_RUN;
            halt_sync_q   <= 2'b00;
            resume_sync_q <= 2'b00;
            arreq_sync_q  <= 2'b00;
            ar_seen_q     <= 1'b0;
            ar_go_q       <= 1'b0;
            ar_ack_q      <= 1'b0;
            ar_rdata_q    <= 32'h0;
            ar_err_q      <= 1'b0;
            pc_load_q     <= 1'b0;
            dpc_q         <= 32'h0;
            cause_q       <= 3'd0;
            ebreakm_q     <= 1'b0;
`ifdef DEBUG_HART_STEP_EN
            step_q        <= 1'b0;
            armed_q       <= 1'b0;
            hit_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            halt_sync_q   <= halt_sync_d;
            resume_sync_q <= resume_sync_d;
            arreq_sync_q  <= arreq_sync_d;
            ar_seen_q     <= ar_seen_d;
            ar_go_q       <= ar_go_d;
            ar_ack_q      <= ar_ack_d;
            ar_rdata_q    <= ar_rdata_d;
            ar_err_q      <= ar_err_d;
            pc_load_q     <= pc_load_d;
            dpc_q         <= dpc_d;
            cause_q       <= cause_d;
            ebreakm_q     <= ebreakm_d;
`ifdef DEBUG_HART_STEP_EN
            step_q        <= step_d;
            armed_q       <= armed_d;
            hit_q         <= hit_d;
`endif
        end
    end

    assign HALTED       = (state_q == ST_HALTED);
    assign RESUMEACK    = (state_q == ST_RESUMING);
    assign CORE_STALL   = (state_q == ST_HALTING) || (state_q == ST_HALTED);
    assign CORE_PC_LOAD = pc_load_q;
    assign CORE_PC_NEXT = dpc_q;
    assign AR_ACK       = ar_ack_q;
    assign AR_RDATA     = ar_rdata_q;
    assign AR_ERR       = ar_err_q;
    // GPR port is quiet except during the execute cycle of an access.
    assign GPR_AD       = ar_go_q ? AR_AD[4:0] : 5'd0;
    assign GPR_WE       = gpr_we;
    assign GPR_WD       = gpr_we ? AR_WDATA : 32'h0;

endmodule

// File: tb/tb_debug_hart_ctrl.sv
// tb/tb_debug_hart_ctrl.sv - self-checking bench for debug_hart_ctrl
module tb_debug_hart_ctrl;

    logic        CLK100MHZ = 1'b0;
    logic        TRST_N;
    logic        HALTREQ, RESUMEREQ;
    logic        HALTED, RESUMEACK;
    logic        AR_REQ, AR_WR;
    logic [15:0] AR_AD;
    logic [31:0] AR_WDATA;
    logic        AR_ACK;
    logic [31:0] AR_RDATA;
    logic        AR_ERR;
    logic        CORE_STALL, CORE_IDLE, CORE_RETIRE;
    logic [31:0] CORE_PC;
    logic        CORE_PC_LOAD;
    logic [31:0] CORE_PC_NEXT;
    logic [4:0]  GPR_AD;
    logic [31:0] GPR_RD;
    logic        GPR_WE;
    logic [31:0] GPR_WD;

    debug_hart_ctrl dut (
        .CLK100MHZ(CLK100MHZ), .TRST_N(TRST_N),
        .HALTREQ(HALTREQ), .RESUMEREQ(RESUMEREQ),
        .HALTED(HALTED), .RESUMEACK(RESUMEACK),
        .AR_REQ(AR_REQ), .AR_WR(AR_WR), .AR_AD(AR_AD), .AR_WDATA(AR_WDATA),
        .AR_ACK(AR_ACK), .AR_RDATA(AR_RDATA), .AR_ERR(AR_ERR),
        .CORE_STALL(CORE_STALL), .CORE_IDLE(CORE_IDLE), .CORE_RETIRE(CORE_RETIRE),
        .CORE_PC(CORE_PC), .CORE_PC_LOAD(CORE_PC_LOAD), .CORE_PC_NEXT(CORE_PC_NEXT),
        .GPR_AD(GPR_AD), .GPR_RD(GPR_RD), .GPR_WE(GPR_WE), .GPR_WD(GPR_WD)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int          checks = 0;
    int          errors = 0;

    // Register file behind the GPR port, and the bench's own view of it.
    logic [31:0] gpr_mem [32];
    logic [31:0] ref_gpr [32];
    int          we_cnt = 0;
    logic [4:0]  we_ad;
    logic [31:0] we_wd;
    int          pcl_cnt = 0;
    logic [31:0] pcl_val;

    assign GPR_RD = gpr_mem[GPR_AD];

    always @(negedge CLK100MHZ) begin
        if (!TRST_N) begin
            for (int i = 0; i < 32; i++) gpr_mem[i] = ref_gpr[i];
        end else begin
            if (GPR_WE === 1'b1) begin
                gpr_mem[GPR_AD] = GPR_WD;
                we_cnt = we_cnt + 1;
                we_ad  = GPR_AD;
                we_wd  = GPR_WD;
            end
            if (CORE_PC_LOAD === 1'b1) begin
                pcl_cnt = pcl_cnt + 1;
                pcl_val = CORE_PC_NEXT;
            end
        end
    end

    // Reference model of the debug-visible hart state.
    bit          m_halted;
    logic [31:0] m_dpc;
    bit          m_ebreakm, m_step;
    int          m_cause;
    logic        ack_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_access(input bit wr, input logic [15:0] ad, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
        int n;
        rd = 32'h0;
        er = 1'b0;
        if (!m_halted) begin
            er = 1'b1;
        end else if (ad >= 16'h1000 && ad <= 16'h101F) begin
            n = int'(ad) - 'h1000;
            if (wr) begin
                if (n != 0) ref_gpr[n] = wd;
            end else begin
                rd = (n == 0) ? 32'h0 : ref_gpr[n];
            end
        end else if (ad == 16'h07B0) begin
            if (wr) begin
                m_ebreakm = wd[15];
`ifdef DEBUG_HART_STEP_EN
                m_step = wd[2];
`endif
            end else begin
                rd = 32'h4000_0003 + (m_ebreakm ? 32'h8000 : 32'h0) + 32'(m_cause * 64) + (m_step ? 32'h4 : 32'h0);
            end
        end else if (ad == 16'h07B1) begin
            if (wr) m_dpc = wd;
            else rd = m_dpc;
        end else if (ad == 16'h0301 && !wr) begin
            rd = 32'h4000_1105;
        end else begin
            er = 1'b1;
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic do_access(input string tag, input bit wr, input logic [15:0] ad, input logic [31:0] wd);
        logic [31:0] exp_rd;
        logic        exp_er;
        logic        prev;
        bit          got;
        model_access(wr, ad, wd, exp_rd, exp_er);
        AR_WR    = wr;
        AR_AD    = ad;
        AR_WDATA = wd;
        prev     = AR_ACK;
        AR_REQ   = ~AR_REQ;
        ack_exp  = ~ack_exp;
        got      = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(1);
            if (AR_ACK !== prev) got = 1;
        end
        check({tag, "_ack"}, {31'h0, AR_ACK}, {31'h0, ack_exp});
        check({tag, "_err"}, {31'h0, AR_ERR}, {31'h0, exp_er});
        if (!wr) check({tag, "_rdata"}, AR_RDATA, exp_rd);
        tick(1);
    endtask

    task automatic wait_for(input string tag, input bit sel_ack, input logic val, input int bound);
        logic cur;
        cur = sel_ack ? RESUMEACK : HALTED;
        for (int i = 0; i < bound && cur !== val; i++) begin
            tick(1);
            cur = sel_ack ? RESUMEACK : HALTED;
        end
        check(tag, {31'h0, cur}, {31'h0, val});
    endtask

    task automatic halt_at(input logic [31:0] pc);
        CORE_PC = pc;
        HALTREQ = 1'b1;
        wait_for("halt", 1'b0, 1'b1, 12);
        m_halted = 1;
        m_dpc    = pc;
        m_cause  = 3;
    endtask

    initial begin
        int          sel;
        int          cnt0;
        logic [15:0] ad;
        logic [31:0] pc;

        TRST_N = 1'b0; HALTREQ = 1'b0; RESUMEREQ = 1'b0;
        AR_REQ = 1'b0; AR_WR = 1'b0; AR_AD = 16'h0; AR_WDATA = 32'h0;
        CORE_IDLE = 1'b1; CORE_RETIRE = 1'b0; CORE_PC = 32'h0;
        for (int i = 0; i < 32; i++) ref_gpr[i] = $urandom;
        m_halted = 0; m_dpc = 32'h0; m_ebreakm = 0; m_step = 0; m_cause = 0; ack_exp = 1'b0;
        tick(4);
        TRST_N = 1'b1;
        tick(2);

        check("rst_halted", {31'h0, HALTED}, 32'h0);
        check("rst_resumeack", {31'h0, RESUMEACK}, 32'h0);
        check("rst_stall", {31'h0, CORE_STALL}, 32'h0);
        check("rst_ack", {31'h0, AR_ACK}, 32'h0);
        check("rst_rdata", AR_RDATA, 32'h0);
        check("rst_pcload", {31'h0, CORE_PC_LOAD}, 32'h0);

        do_access("run_rd_dpc", 1'b0, 16'h07B1, 32'h0);

        CORE_PC = 32'h0000_0200;
        HALTREQ = 1'b1;
        wait_for("halt_5cyc", 1'b0, 1'b1, 5);
        m_halted = 1; m_dpc = 32'h0000_0200; m_cause = 3;
        check("halt_stall", {31'h0, CORE_STALL}, 32'h1);
        do_access("rd_dpc", 1'b0, 16'h07B1, 32'h0);
        do_access("rd_dcsr", 1'b0, 16'h07B0, 32'h0);
        check("dcsr_c3", AR_RDATA, 32'h4000_00C3);
        do_access("rd_misa", 1'b0, 16'h0301, 32'h0);
        do_access("rd_unmapped", 1'b0, 16'h2000, 32'h0);
        do_access("wr_misa", 1'b1, 16'h0301, 32'h1234_5678);

        cnt0 = we_cnt;
        do_access("wr_x5", 1'b1, 16'h1005, 32'hDEAD_BEEF);
        check("x5_we_cnt", 32'(we_cnt - cnt0), 32'h1);
        check("x5_ad", {27'h0, we_ad}, 32'h5);
        check("x5_wd", we_wd, 32'hDEAD_BEEF);
        cnt0 = we_cnt;
        do_access("wr_x0", 1'b1, 16'h1000, 32'h1111_2222);
        check("x0_no_we", 32'(we_cnt - cnt0), 32'h0);
        do_access("rd_x0", 1'b0, 16'h1000, 32'h0);
        do_access("rd_x5", 1'b0, 16'h1005, 32'h0);

        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0, 1, 2: ad = 16'h1000 + 16'($urandom_range(0, 31));
                3:       ad = 16'h07B0;
                4:       ad = 16'h07B1;
                5:       ad = 16'h0301;
                default: ad = 16'($urandom);
            endcase
            do_access("rand", 1'($urandom_range(0, 1)), ad, $urandom);
        end
        check("rand_we_total_x5", gpr_mem[5], ref_gpr[5]);

        RESUMEREQ = 1'b1;
        tick(8);
        check("both_stay_halted", {31'h0, HALTED}, 32'h1);

        HALTREQ = 1'b0;
        RESUMEREQ = 1'b0;
        do_access("wr_dcsr0", 1'b1, 16'h07B0, 32'h0);
        do_access("wr_dpc", 1'b1, 16'h07B1, 32'h8000_0000);
        cnt0 = pcl_cnt;
        RESUMEREQ = 1'b1;
        wait_for("resumeack", 1'b1, 1'b1, 6);
        check("res_halted0", {31'h0, HALTED}, 32'h0);
        check("res_stall0", {31'h0, CORE_STALL}, 32'h0);
        HALTREQ = 1'b1;
        tick(6);
        check("res_ack_held", {31'h0, RESUMEACK}, 32'h1);
        check("res_haltreq_ignored", {31'h0, HALTED}, 32'h0);
        check("pcload_once", 32'(pcl_cnt - cnt0), 32'h1);
        check("pcload_val", pcl_val, 32'h8000_0000);
        pc = $urandom & 32'hFFFF_FFFC;
        CORE_PC = pc;
        RESUMEREQ = 1'b0;
        m_halted = 0;
        wait_for("res_ack_drop", 1'b1, 1'b0, 6);
        wait_for("rehalt", 1'b0, 1'b1, 10);
        m_halted = 1; m_dpc = pc; m_cause = 3;
        do_access("rehalt_dpc", 1'b0, 16'h07B1, 32'h0);
        check("pcload_not_again", 32'(pcl_cnt - cnt0), 32'h1);

        HALTREQ = 1'b0;
        do_access("wr_step", 1'b1, 16'h07B0, 32'h0000_0004);
        pc = $urandom & 32'hFFFF_FFFC;
        RESUMEREQ = 1'b1;
        wait_for("step_resumeack", 1'b1, 1'b1, 6);
        RESUMEREQ = 1'b0;
        m_halted = 0;
        wait_for("step_run", 1'b1, 1'b0, 6);
        tick(2);
        CORE_PC = pc;
        CORE_RETIRE = 1'b1;
        tick(1);
        CORE_RETIRE = 1'b0;
`ifdef DEBUG_HART_STEP_EN
        wait_for("step_halt", 1'b0, 1'b1, 8);
        m_halted = 1; m_dpc = pc; m_cause = 4;
        do_access("step_dcsr", 1'b0, 16'h07B0, 32'h0);
        check("step_cause4", {29'h0, AR_RDATA[8:6]}, 32'h4);
`else
        tick(8);
        check("nostep_run", {31'h0, HALTED}, 32'h0);
        halt_at(pc);
        do_access("nostep_dcsr", 1'b0, 16'h07B0, 32'h0);
`endif

        do_access("wr_ebreakm", 1'b1, 16'h07B0, 32'h0000_8004);
        HALTREQ = 1'b1;
        TRST_N = 1'b0;
        #2;
        check("trst_stall", {31'h0, CORE_STALL}, 32'h0);
        check("trst_halted", {31'h0, HALTED}, 32'h0);
        check("trst_ack", {31'h0, AR_ACK}, 32'h0);
        check("trst_rdata", AR_RDATA, 32'h0);
        AR_REQ = 1'b0;
        ack_exp = 1'b0;
        m_halted = 0; m_dpc = 32'h0; m_ebreakm = 0; m_step = 0; m_cause = 0;
        tick(3);
        TRST_N = 1'b1;
        halt_at(32'h0000_1234);
        do_access("post_rst_dcsr", 1'b0, 16'h07B0, 32'h0);
        check("post_rst_dcsr_val", AR_RDATA, 32'h4000_00C3);
        do_access("post_rst_dpc", 1'b0, 16'h07B1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
